// File: rtl/adder_accum_ctrl.sv
// adder_accum_ctrl: folds a stream of operand pairs into one sum through a shared 3-input adder
//
// adder ports: a_i, b_i, c_i (width_p) -> sum_o (width_p+2, full unsigned sum)
// adder_accum_ctrl ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   v_i, ready_o            operand pair handshake
//   a_i, b_i, last_i        operand pair, final-pair marker
//   v_o, yumi_i             result handshake
//   sum_o, count_o          accumulated sum, pairs accepted

module adder #(
    parameter int width_p = 8
) (
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    input  logic [width_p-1:0] c_i,
    output logic [width_p+1:0] sum_o
);
    assign sum_o = {2'b00, a_i} + {2'b00, b_i} + {2'b00, c_i};
endmodule

module adder_accum_ctrl #(
    parameter int width_p = 4,
    parameter int ops_p = 4,
    localparam int acc_width_lp = width_p + $clog2(2*ops_p),
    localparam int cnt_width_lp = $clog2(ops_p+1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    v_i,
    output logic                    ready_o,
    input  logic [width_p-1:0]      a_i,
    input  logic [width_p-1:0]      b_i,
    input  logic                    last_i,
    output logic                    v_o,
    output logic [acc_width_lp-1:0] sum_o,
    output logic [cnt_width_lp-1:0] count_o,
    input  logic                    yumi_i
);
    typedef enum logic {eAccum, eDone} state_e;
    state_e state_q, state_d;
    logic [acc_width_lp-1:0] acc_q, acc_d;
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic [acc_width_lp+1:0] add_sum;
    logic fire;
    adder #(.width_p(acc_width_lp)) add_u (
        .a_i  (acc_q),
        .b_i  ({{(acc_width_lp-width_p){1'b0}}, a_i}),
        .c_i  ({{(acc_width_lp-width_p){1'b0}}, b_i}),
        .sum_o(add_sum)
    );
    assign fire = v_i & ready_o;
    assign sum_o = acc_q;
    assign count_o = cnt_q;
    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        ready_o = 1'b0;
        v_o = 1'b0;
        if (state_q == eAccum) begin
            ready_o = 1'b1;
            if (fire) begin
                acc_d = add_sum[acc_width_lp-1:0];
                cnt_d = cnt_q + cnt_width_lp'(1);
                state_d = (cnt_q == cnt_width_lp'(ops_p-1) || last_i) ? eDone : eAccum;
            end
        end else begin
            v_o = 1'b1;
            // yumi clears the result; the next pair waits one cycle
            if (yumi_i) begin
                acc_d = '0;
                cnt_d = '0;
                state_d = eAccum;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= eAccum;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
    // the accumulator width guarantees the adder's upper bits stay clear
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(fire && add_sum[acc_width_lp+1:acc_width_lp] != 2'b00));
            assert (!(ready_o && v_o));
            assert (cnt_q <= cnt_width_lp'(ops_p));
        end
    end
endmodule

// File: tb/tb_adder_accum_ctrl.sv
module tb_adder_accum_ctrl;
    localparam int W = 4;
    localparam int OPS = 4;
    logic clk = 1'b0;
    logic reset_i = 1'b0, v_i = 1'b0, last_i = 1'b0, yumi_i = 1'b0;
    logic [W-1:0] a_i = '0, b_i = '0;
    logic ready_o, v_o;
    logic [6:0] sum_o;
    logic [2:0] count_o;
    int vectors = 0, errors = 0;
    int m_sum = 0, m_cnt = 0;
    bit m_done = 0, started = 0;

    adder_accum_ctrl #(.width_p(W), .ops_p(OPS)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .last_i(last_i), .v_o(v_o),
        .sum_o(sum_o), .count_o(count_o), .yumi_i(yumi_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // transaction-level reference: a running total that closes after OPS pairs or on last
    always @(posedge clk) begin
        if (reset_i) begin
            m_sum = 0; m_cnt = 0; m_done = 0; started = 1;
        end else if (m_done) begin
            if (yumi_i) begin m_sum = 0; m_cnt = 0; m_done = 0; end
        end else if (v_i) begin
            m_sum = m_sum + int'(a_i) + int'(b_i);
            m_cnt = m_cnt + 1;
            m_done = (m_cnt == OPS) || last_i;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ready_o", int'(ready_o), m_done ? 0 : 1);
            chk("v_o", int'(v_o), m_done ? 1 : 0);
            chk("sum_o", int'(sum_o), m_sum);
            chk("count_o", int'(count_o), m_cnt);
        end
    end

    task automatic cyc(input bit v, input int a, input int b, input bit last,
                       input bit yumi, input bit rst);
        v_i = v; a_i = W'(a); b_i = W'(b); last_i = last; yumi_i = yumi; reset_i = rst;
        @(posedge clk);
        #1;
        v_i = 0; last_i = 0; yumi_i = 0; reset_i = 0;
    endtask

    task automatic pin(input string tag, input int s, input int c, input bit v, input bit r);
        chk({tag, ".sum"}, int'(sum_o), s);
        chk({tag, ".count"}, int'(count_o), c);
        chk({tag, ".v_o"}, int'(v_o), int'(v));
        chk({tag, ".ready"}, int'(ready_o), int'(r));
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 1);
        pin("reset", 0, 0, 0, 1);
        cyc(1, 1, 2, 0, 0, 0); cyc(1, 3, 4, 0, 0, 0);
        cyc(1, 5, 6, 0, 0, 0); cyc(1, 7, 8, 0, 0, 0);
        pin("basic", 36, 4, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        pin("basic_yumi", 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 15, 15, 0, 0, 0);
        pin("max", 120, 4, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 15, 15, 0, 0, 0); cyc(1, 1, 0, 1, 0, 0);
        pin("early_last", 31, 2, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 9, 9, 0, 0, 0);
            pin("backpressure", 31, 2, 1, 0);
        end
        cyc(1, 9, 9, 0, 1, 0);
        pin("bubble", 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0);
        pin("stray_yumi", 0, 0, 0, 1);
        cyc(1, 2, 3, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 4, 5, 0, 0, 0); cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0); cyc(1, 1, 1, 0, 0, 0);
        pin("gapped", 16, 4, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 3, 4, 1, 0, 0);
        pin("one_pair", 7, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 6, 6, 0, 0, 0); cyc(1, 7, 7, 0, 0, 0);
        pin("partial", 26, 2, 0, 1);
        cyc(1, 9, 9, 1, 1, 1);
        pin("mid_reset", 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0, 0);
        pin("after_reset", 8, 4, 1, 0);
        cyc(0, 0, 0, 0, 1, 1);
        pin("done_reset", 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
